// File: rtl/alu_share_arb_if.sv
// Bundle between the shared-ALU scheduler, its two requesters, the response consumer
// and the external combinational ALU instance.
interface alu_share_arb_if #(
  parameter int W  = 4,
  parameter int FW = 3
);
  logic          req0_valid;
  logic          req0_ready;
  logic [W-1:0]  req0_a;
  logic [W-1:0]  req0_b;
  logic [FW-1:0] req0_f;

  logic          req1_valid;
  logic          req1_ready;
  logic [W-1:0]  req1_a;
  logic [W-1:0]  req1_b;
  logic [FW-1:0] req1_f;

  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [FW-1:0] alu_f;
  logic [W-1:0]  alu_y;
  logic          alu_zf;
  logic          alu_of;
  logic          alu_cf;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [W-1:0]  rsp_y;
  logic          rsp_zf;
  logic          rsp_of;
  logic          rsp_cf;

  logic          busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_f,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_f,
    output req1_ready,
    output alu_a, alu_b, alu_f,
    input  alu_y, alu_zf, alu_of, alu_cf,
    output rsp_valid, rsp_id, rsp_y, rsp_zf, rsp_of, rsp_cf,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_f,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_f,
    input  req1_ready,
    input  alu_a, alu_b, alu_f,
    output alu_y, alu_zf, alu_of, alu_cf,
    input  rsp_valid, rsp_id, rsp_y, rsp_zf, rsp_of, rsp_cf,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin scheduler time-sharing one external combinational ALU between two
// requesters; one operation in flight, registered result returned with requester id.
module alu_share_arb #(
  parameter int W  = 4,
  parameter int FW = 3
) (
  input  logic            clk,
  input  logic            rst,
  alu_share_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  logic          prio;
  logic          cur_id;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [FW-1:0] op_f;

  logic          rsp_valid;
  logic          rsp_id;
  logic [W-1:0]  rsp_y;
  logic          rsp_zf;
  logic          rsp_of;
  logic          rsp_cf;
  logic          busy;

  logic          grant_any;
  logic          grant_id;
  logic          accept;

  // Grant selection: a lone requester wins, a tie goes to the priority pointer.
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = prio;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end else begin
      grant_id = 1'b0;
    end
    accept = (state == IDLE) && grant_any;
  end

  assign bus.req0_ready = accept && (grant_id == 1'b0);
  assign bus.req1_ready = accept && (grant_id == 1'b1);

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = EXEC;
        end else begin
          state_next = IDLE;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_valid && bus.rsp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand latch, result capture and response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio      <= 1'b0;
      cur_id    <= 1'b0;
      op_a      <= {W{1'b0}};
      op_b      <= {W{1'b0}};
      op_f      <= {FW{1'b0}};
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_y     <= {W{1'b0}};
      rsp_zf    <= 1'b0;
      rsp_of    <= 1'b0;
      rsp_cf    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            op_a   <= grant_id ? bus.req1_a : bus.req0_a;
            op_b   <= grant_id ? bus.req1_b : bus.req0_b;
            op_f   <= grant_id ? bus.req1_f : bus.req0_f;
            cur_id <= grant_id;
            prio   <= ~grant_id;
          end
        end
        EXEC: begin
          rsp_y     <= bus.alu_y;
          rsp_zf    <= bus.alu_zf;
          rsp_of    <= bus.alu_of;
          rsp_cf    <= bus.alu_cf;
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          // Result and flags stay visible after the handshake; only valid drops.
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alu_a     = op_a;
  assign bus.alu_b     = op_b;
  assign bus.alu_f     = op_f;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_y     = rsp_y;
  assign bus.rsp_zf    = rsp_zf;
  assign bus.rsp_of    = rsp_of;
  assign bus.rsp_cf    = rsp_cf;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: behavioural ALU on the ALU side, scoreboard
// of expected responses popped on every response handshake.
module tb_alu_share_arb;

  typedef struct packed {
    logic       id;
    logic [3:0] y;
    logic       zf;
    logic       of;
    logic       cf;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  alu_share_arb_if #(.W(4), .FW(3)) bus ();

  alu_share_arb #(.W(4), .FW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 4-bit ALU returning {y, zf, of, cf}.
  function automatic logic [6:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] f);
    logic [4:0] w;
    logic [3:0] y;
    logic       of;
    logic       cf;
    of = 1'b0;
    cf = 1'b0;
    w  = 5'd0;
    case (f)
      3'd0: begin
        w  = {1'b0, a} + {1'b0, b};
        y  = w[3:0];
        cf = w[4];
        of = (a[3] == b[3]) && (y[3] != a[3]);
      end
      3'd1: begin
        w  = {1'b0, a} - {1'b0, b};
        y  = w[3:0];
        cf = w[4];
        of = (a[3] != b[3]) && (y[3] != a[3]);
      end
      3'd2: y = ~a;
      3'd3: y = a & b;
      3'd4: y = a | b;
      3'd5: y = a ^ b;
      3'd6: y = (a < b) ? 4'd1 : 4'd0;
      default: y = (a == b) ? 4'd1 : 4'd0;
    endcase
    return {y, (y == 4'd0), of, cf};
  endfunction

  always_comb begin
    {bus.alu_y, bus.alu_zf, bus.alu_of, bus.alu_cf} = alu_ref(bus.alu_a, bus.alu_b, bus.alu_f);
  end

  // Response monitor: pop and compare on every handshake, and guard mutual exclusion of readies.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected: got id=%0d y=%0d, required no response", bus.rsp_id, bus.rsp_y);
      end else begin
        e = sb.pop_front();
        if ({bus.rsp_id, bus.rsp_y, bus.rsp_zf, bus.rsp_of, bus.rsp_cf} !== e) begin
          miscompares++;
          $display("FAIL rsp_data: got id=%0d y=%0d zf=%0d of=%0d cf=%0d, required id=%0d y=%0d zf=%0d of=%0d cf=%0d",
                   bus.rsp_id, bus.rsp_y, bus.rsp_zf, bus.rsp_of, bus.rsp_cf,
                   e.id, e.y, e.zf, e.of, e.cf);
        end
      end
    end
    if (bus.req0_ready && bus.req1_ready) begin
      miscompares++;
      $display("FAIL both_ready: got req0_ready=1 req1_ready=1, required at most one");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.rsp_valid) && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    if (sb.size() != 0 || bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending rsp_valid=%0d, required 0 pending", sb.size(), bus.rsp_valid);
      sb.delete();
    end
  endtask

  task automatic do_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] f, input exp_t e);
    bit got;
    got = 1'b0;
    if (id) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_f = f; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_f = f; bus.req0_valid = 1'b1;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((id == 1'b0 && bus.req0_ready) || (id == 1'b1 && bus.req1_ready)) begin
        got = 1'b1;
        sb.push_back(e);
      end
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL grant_timeout: requester %0d got no ready, required a grant", id);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_y, bus.rsp_zf, bus.rsp_of, bus.rsp_cf} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_rsp: got valid=%0d busy=%0d id=%0d y=%0d flags=%0d%0d%0d, required all 0",
               bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_y, bus.rsp_zf, bus.rsp_of, bus.rsp_cf);
    end
    vectors++;
    if ({bus.alu_a, bus.alu_b, bus.alu_f} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_alu: got a=%0d b=%0d f=%0d, required 0", bus.alu_a, bus.alu_b, bus.alu_f);
    end
    tick();
  endtask

  task automatic test_single_op();
    bus.rsp_ready = 1'b1;
    bus.req0_a = 4'd7; bus.req0_b = 4'd1; bus.req0_f = 3'd0; bus.req0_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ready: got r0=%0d r1=%0d, required 1 0", bus.req0_ready, bus.req1_ready);
    end
    sb.push_back(exp_t'{1'b0, 4'd8, 1'b0, 1'b1, 1'b0});
    tick();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1 || bus.alu_a !== 4'd7 || bus.alu_b !== 4'd1) begin
      miscompares++;
      $display("FAIL single_exec: got valid=%0d busy=%0d a=%0d b=%0d, required 0 1 7 1",
               bus.rsp_valid, bus.busy, bus.alu_a, bus.alu_b);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 4'd8 || bus.rsp_of !== 1'b1 || bus.rsp_id !== 1'b0) begin
      miscompares++;
      $display("FAIL single_rsp: got valid=%0d y=%0d of=%0d id=%0d, required 1 8 1 0",
               bus.rsp_valid, bus.rsp_y, bus.rsp_of, bus.rsp_id);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_after: got valid=%0d busy=%0d, required 0 0", bus.rsp_valid, bus.busy);
    end
    tick();
  endtask

  task automatic test_subtract();
    bus.rsp_ready = 1'b1;
    do_op(1'b1, 4'd3, 4'd5, 3'd1, exp_t'{1'b1, 4'd14, 1'b0, 1'b0, 1'b1});
    wait_drain();
    do_op(1'b1, 4'd5, 4'd5, 3'd1, exp_t'{1'b1, 4'd0, 1'b1, 1'b0, 1'b0});
    wait_drain();
  endtask

  task automatic test_round_robin();
    int         grants;
    logic [3:0] seq;
    grants = 0;
    seq    = 4'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.req0_a = 4'd12; bus.req0_b = 4'd10; bus.req0_f = 3'd3; bus.req0_valid = 1'b1;
    bus.req1_a = 4'd12; bus.req1_b = 4'd10; bus.req1_f = 3'd5; bus.req1_valid = 1'b1;
    for (int i = 0; i < 40 && grants < 4; i++) begin
      @(negedge clk);
      if (bus.req0_ready) begin
        sb.push_back(exp_t'{1'b0, 4'd8, 1'b0, 1'b0, 1'b0});
        seq[grants] = 1'b0;
        grants++;
      end else if (bus.req1_ready) begin
        sb.push_back(exp_t'{1'b1, 4'd6, 1'b0, 1'b0, 1'b0});
        seq[grants] = 1'b1;
        grants++;
      end
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    vectors++;
    if (grants != 4 || seq !== 4'b1010) begin
      miscompares++;
      $display("FAIL rr_order: got %0d grants seq=%b, required 4 grants seq=1010 (lsb first)", grants, seq);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    bus.req0_a = 4'd2; bus.req0_b = 4'd3; bus.req0_f = 3'd6; bus.req0_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_grant0: got req0_ready=%0d, required 1", bus.req0_ready);
    end else begin
      sb.push_back(exp_t'{1'b0, 4'd1, 1'b0, 1'b0, 1'b0});
    end
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_a = 4'd1; bus.req1_b = 4'd1; bus.req1_f = 3'd0; bus.req1_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 4'd1 || bus.rsp_id !== 1'b0 || bus.req1_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold: cycle %0d got valid=%0d y=%0d id=%0d r1=%0d, required 1 1 0 0",
                 i, bus.rsp_valid, bus.rsp_y, bus.rsp_id, bus.req1_ready);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: got req1_ready=%0d in handshake cycle, required 0", bus.req1_ready);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (bus.req1_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_y !== 4'd1) begin
      miscompares++;
      $display("FAIL bp_regrant: got r1=%0d valid=%0d y=%0d, required 1 0 1",
               bus.req1_ready, bus.rsp_valid, bus.rsp_y);
    end
    if (bus.req1_ready === 1'b1) begin
      sb.push_back(exp_t'{1'b1, 4'd2, 1'b0, 1'b0, 1'b0});
    end
    tick();
    bus.req1_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid_op();
    bus.rsp_ready = 1'b1;
    bus.req0_a = 4'd4; bus.req0_b = 4'd4; bus.req0_f = 3'd7; bus.req0_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rmo_grant: got req0_ready=%0d, required 1", bus.req0_ready);
    end
    tick();
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rmo_exec: got busy=%0d, required 1", bus.busy);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rmo_flush: cycle %0d got valid=%0d busy=%0d, required 0 0", i, bus.rsp_valid, bus.busy);
      end
      tick();
    end
    bus.req0_valid = 1'b1;
    bus.req1_a = 4'd9; bus.req1_b = 4'd2; bus.req1_f = 3'd0; bus.req1_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rmo_prio: got r0=%0d r1=%0d, required 1 0", bus.req0_ready, bus.req1_ready);
    end
    if (bus.req0_ready === 1'b1) begin
      sb.push_back(exp_t'{1'b0, 4'd1, 1'b0, 1'b0, 1'b0});
    end
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_drain();
    do_op(1'b1, 4'd9, 4'd2, 3'd0, exp_t'{1'b1, 4'd11, 1'b0, 1'b0, 1'b0});
    wait_drain();
  endtask

  task automatic test_operand_stability();
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] f;
    exp_t       e;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      f = 3'(k);
      bus.req0_a = a; bus.req0_b = b; bus.req0_f = f; bus.req0_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.req0_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stab_grant: f=%0d got req0_ready=%0d, required 1", f, bus.req0_ready);
      end else begin
        e.id = 1'b0;
        {e.y, e.zf, e.of, e.cf} = alu_ref(a, b, f);
        sb.push_back(e);
      end
      tick();
      bus.req0_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
        bus.req0_a = 4'($urandom_range(0, 15));
        bus.req0_b = 4'($urandom_range(0, 15));
        bus.req0_f = 3'($urandom_range(0, 7));
        @(negedge clk);
        vectors++;
        if (bus.alu_a !== a || bus.alu_b !== b || bus.alu_f !== f) begin
          miscompares++;
          $display("FAIL stab_ops: f=%0d cycle %0d got a=%0d b=%0d f=%0d, required %0d %0d %0d",
                   k, c, bus.alu_a, bus.alu_b, bus.alu_f, a, b, f);
        end
        tick();
      end
      wait_drain();
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vectors     = 0;
    miscompares = 0;
    rst            = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_a     = 4'd0;
    bus.req0_b     = 4'd0;
    bus.req0_f     = 3'd0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = 4'd0;
    bus.req1_b     = 4'd0;
    bus.req1_f     = 3'd0;
    bus.rsp_ready  = 1'b0;
    #1;
    test_reset();
    test_single_op();
    test_subtract();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_operand_stability();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
